// File: rtl/serial_loader_if.sv
// Host-side bus bundle for serial_loader: UART byte channel, program RAM ports
// and CPU start/halt handshake. master = loader side, slave = environment side.
interface serial_loader_if #(
    parameter int addr_width = 9
);
    logic [7:0]            rx_byte;
    logic                  received;
    logic [7:0]            tx_byte;
    logic                  transmit;
    logic                  is_transmitting;
    logic [addr_width-1:0] mem_raddr;
    logic [7:0]            mem_dread;
    logic [addr_width-1:0] mem_waddr;
    logic [7:0]            mem_dwrite;
    logic                  mem_write_en;
    logic                  cpu_start;
    logic [addr_width-1:0] cpu_startaddr;
    logic                  cpu_halted;
    logic                  busy;

    modport master (
        input  rx_byte, received, is_transmitting, mem_dread, cpu_halted,
        output tx_byte, transmit, mem_raddr, mem_waddr, mem_dwrite, mem_write_en,
               cpu_start, cpu_startaddr, busy
    );

    modport slave (
        output rx_byte, received, is_transmitting, mem_dread, cpu_halted,
        input  tx_byte, transmit, mem_raddr, mem_waddr, mem_dwrite, mem_write_en,
               cpu_start, cpu_startaddr, busy
    );
endinterface

// File: rtl/serial_loader.sv
// Serial monitor: loads/reads program RAM over UART and starts the CPU, reporting on halt.
// addr_width is expected to lie in 9..16; addresses are the low bits of the {hi,lo} byte pair.
module serial_loader #(
    parameter int addr_width = 9
) (
    input  logic           clk,
    input  logic           rst,
    serial_loader_if.master bus_if
);
    typedef enum logic [3:0] {
        S_IDLE, S_ADDRH, S_ADDRL, S_COUNT, S_LOAD, S_RDADDR, S_RDWAIT1,
        S_RDWAIT2, S_RDSEND, S_TXGUARD, S_RUN, S_REPLY
    } state_t;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_READ = 8'h52;
    localparam logic [7:0] CMD_GO   = 8'h47;
    localparam logic [7:0] CH_DOT   = 8'h2E;
    localparam logic [7:0] CH_HALT  = 8'h48;
    localparam logic [7:0] CH_ERR   = 8'h3F;
    localparam logic [addr_width-1:0] ADDR_ONE = addr_width'(1);

    state_t                state_q, state_d;
    logic [7:0]            cmd_q, cmd_d;
    logic [7:0]            hi_q, hi_d;
    logic [addr_width-1:0] addr_q, addr_d;
    logic [8:0]            count_q, count_d;
    logic [7:0]            tx_byte_q, tx_byte_d;
    logic                  transmit_q, transmit_d;
    logic [addr_width-1:0] raddr_q, raddr_d;
    logic [addr_width-1:0] waddr_q, waddr_d;
    logic [7:0]            dwrite_q, dwrite_d;
    logic                  we_q, we_d;
    logic                  start_q, start_d;
    logic [addr_width-1:0] startaddr_q, startaddr_d;
    logic                  busy_q, busy_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            hi_q        <= '0;
            addr_q      <= '0;
            count_q     <= '0;
            tx_byte_q   <= '0;
            transmit_q  <= 1'b0;
            raddr_q     <= '0;
            waddr_q     <= '0;
            dwrite_q    <= '0;
            we_q        <= 1'b0;
            start_q     <= 1'b0;
            startaddr_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            hi_q        <= hi_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            tx_byte_q   <= tx_byte_d;
            transmit_q  <= transmit_d;
            raddr_q     <= raddr_d;
            waddr_q     <= waddr_d;
            dwrite_q    <= dwrite_d;
            we_q        <= we_d;
            start_q     <= start_d;
            startaddr_q <= startaddr_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        hi_d        = hi_q;
        addr_d      = addr_q;
        count_d     = count_q;
        tx_byte_d   = tx_byte_q;
        transmit_d  = 1'b0;
        raddr_d     = raddr_q;
        waddr_d     = waddr_q;
        dwrite_d    = dwrite_q;
        we_d        = 1'b0;
        start_d     = 1'b0;
        startaddr_d = startaddr_q;
        busy_d      = busy_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus_if.received) begin
                    if (bus_if.rx_byte == CMD_LOAD || bus_if.rx_byte == CMD_READ ||
                        bus_if.rx_byte == CMD_GO) begin
                        cmd_d   = bus_if.rx_byte;
                        state_d = S_ADDRH;
                    end else begin
                        tx_byte_d = CH_ERR;
                        state_d   = S_REPLY;
                    end
                end
            end
            S_ADDRH: begin
                if (bus_if.received) begin
                    hi_d    = bus_if.rx_byte;
                    state_d = S_ADDRL;
                end
            end
            S_ADDRL: begin
                if (bus_if.received) begin
                    addr_d = addr_width'({hi_q, bus_if.rx_byte});
                    if (cmd_q == CMD_GO) begin
                        startaddr_d = addr_width'({hi_q, bus_if.rx_byte});
                        start_d     = 1'b1;
                        busy_d      = 1'b1;
                        state_d     = S_RUN;
                    end else begin
                        state_d = S_COUNT;
                    end
                end
            end
            S_COUNT: begin
                if (bus_if.received) begin
                    // A zero count byte stands for a full 256-byte block.
                    count_d = (bus_if.rx_byte == 8'd0) ? 9'd256 : {1'b0, bus_if.rx_byte};
                    state_d = (cmd_q == CMD_LOAD) ? S_LOAD : S_RDADDR;
                end
            end
            S_LOAD: begin
                if (bus_if.received) begin
                    we_d     = 1'b1;
                    waddr_d  = addr_q;
                    dwrite_d = bus_if.rx_byte;
                    addr_d   = addr_q + ADDR_ONE;
                    count_d  = count_q - 9'd1;
                    if (count_q == 9'd1) begin
                        tx_byte_d = CH_DOT;
                        state_d   = S_REPLY;
                    end
                end
            end
            S_RDADDR: begin
                raddr_d = addr_q;
                state_d = S_RDWAIT1;
            end
            S_RDWAIT1: state_d = S_RDWAIT2;
            S_RDWAIT2: state_d = S_RDSEND;
            S_RDSEND: begin
                if (!bus_if.is_transmitting) begin
                    tx_byte_d  = bus_if.mem_dread;
                    transmit_d = 1'b1;
                    addr_d     = addr_q + ADDR_ONE;
                    count_d    = count_q - 9'd1;
                    state_d    = S_TXGUARD;
                end
            end
            // One dead cycle so the transmitter's busy flag is up before the next check.
            S_TXGUARD: state_d = (count_q != 9'd0) ? S_RDADDR : S_IDLE;
            S_RUN: begin
                if (bus_if.cpu_halted) begin
                    busy_d    = 1'b0;
                    tx_byte_d = CH_HALT;
                    state_d   = S_REPLY;
                end
            end
            S_REPLY: begin
                if (!bus_if.is_transmitting) begin
                    transmit_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus_if.tx_byte       = tx_byte_q;
    assign bus_if.transmit      = transmit_q;
    assign bus_if.mem_raddr     = raddr_q;
    assign bus_if.mem_waddr     = waddr_q;
    assign bus_if.mem_dwrite    = dwrite_q;
    assign bus_if.mem_write_en  = we_q;
    assign bus_if.cpu_start     = start_q;
    assign bus_if.cpu_startaddr = startaddr_q;
    assign bus_if.busy          = busy_q;
endmodule

// File: tb/tb_serial_loader.sv
// Directed bench for serial_loader with RAM/UART models and write/transmit scoreboards.
module tb_serial_loader;
    localparam int AW = 9;

    logic clk = 1'b0;
    logic rst;

    serial_loader_if #(.addr_width(AW)) bus ();
    serial_loader #(.addr_width(AW)) dut (.clk(clk), .rst(rst), .bus_if(bus));

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [AW+7:0]  exp_wr[$];
    logic [7:0]     exp_tx[$];
    logic [7:0]     ram [0:(1<<AW)-1];
    logic [7:0]     rd_p1;
    int             uart_cnt = 0;
    int             start_cycles = 0;
    logic [AW-1:0]  exp_startaddr = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // RAM with two-cycle read latency from the registered read address
    always @(posedge clk) begin
        if (bus.mem_write_en) ram[bus.mem_waddr] <= bus.mem_dwrite;
        rd_p1         <= ram[bus.mem_raddr];
        bus.mem_dread <= rd_p1;
    end

    // UART transmitter model (10-cycle busy) and transmit scoreboard
    always @(negedge clk) begin
        if (bus.transmit === 1'b1) begin
            tests++;
            assert (exp_tx.size() != 0) else begin
                fails++;
                $error("FAIL tx_unexpected: got byte 0x%0h, expected no transmit", bus.tx_byte);
            end
            if (exp_tx.size() != 0) check("tx_byte", bus.tx_byte, exp_tx.pop_front());
            check("tx_while_uart_busy", bus.is_transmitting, 0);
            check("tx_while_cpu_busy", bus.busy, 0);
            uart_cnt = 10;
        end else if (uart_cnt > 0) begin
            uart_cnt--;
        end
        bus.is_transmitting = (uart_cnt != 0);
    end

    // Write scoreboard
    always @(negedge clk) begin
        if (bus.mem_write_en === 1'b1) begin
            logic [AW+7:0] e;
            tests++;
            assert (exp_wr.size() != 0) else begin
                fails++;
                $error("FAIL wr_unexpected: got addr 0x%0h data 0x%0h, expected no write",
                       bus.mem_waddr, bus.mem_dwrite);
            end
            if (exp_wr.size() != 0) begin
                e = exp_wr.pop_front();
                check("wr_addr", bus.mem_waddr, e[AW+7:8]);
                check("wr_data", bus.mem_dwrite, e[7:0]);
            end
            check("wr_while_busy", bus.busy, 0);
        end
    end

    // CPU start monitor
    always @(negedge clk) begin
        if (bus.cpu_start === 1'b1) begin
            start_cycles++;
            check("start_with_busy", bus.busy, 1);
        end
        if (bus.busy === 1'b1) check("startaddr_hold", bus.cpu_startaddr, exp_startaddr);
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.rx_byte  = b;
        bus.received = 1'b1;
        @(negedge clk);
        bus.received = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_wr.size() != 0 || exp_tx.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_wr_left", exp_wr.size(), 0);
        check("drain_tx_left", exp_tx.size(), 0);
        exp_wr.delete();
        exp_tx.delete();
        repeat (15) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_tx_byte"},   bus.tx_byte, 0);
        check({tag, "_transmit"},  bus.transmit, 0);
        check({tag, "_raddr"},     bus.mem_raddr, 0);
        check({tag, "_waddr"},     bus.mem_waddr, 0);
        check({tag, "_dwrite"},    bus.mem_dwrite, 0);
        check({tag, "_we"},        bus.mem_write_en, 0);
        check({tag, "_start"},     bus.cpu_start, 0);
        check({tag, "_startaddr"}, bus.cpu_startaddr, 0);
        check({tag, "_busy"},      bus.busy, 0);
    endtask

    function automatic logic [AW+7:0] wr(input int a, input logic [7:0] d);
        logic [AW-1:0] aa;
        aa = AW'(a);
        return {aa, d};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = 8'h00;
        rst            = 1'b1;
        bus.rx_byte    = 8'h00;
        bus.received   = 1'b0;
        bus.cpu_halted = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic load
        exp_wr.push_back(wr(12'h010, 8'hAA));
        exp_wr.push_back(wr(12'h011, 8'hBB));
        exp_wr.push_back(wr(12'h012, 8'hCC));
        exp_tx.push_back(8'h2E);
        send(8'h4C); send(8'h00); send(8'h10); send(8'h03);
        send(8'hAA); send(8'hBB); send(8'hCC);
        drain(200);

        // Read back with UART back-pressure
        exp_tx.push_back(8'hAA); exp_tx.push_back(8'hBB); exp_tx.push_back(8'hCC);
        send(8'h52); send(8'h00); send(8'h10); send(8'h03);
        drain(300);

        // Address wrap at top of RAM
        exp_wr.push_back(wr(12'h1FF, 8'h11));
        exp_wr.push_back(wr(12'h000, 8'h22));
        exp_tx.push_back(8'h2E);
        send(8'h4C); send(8'h01); send(8'hFF); send(8'h02); send(8'h11); send(8'h22);
        drain(200);

        // High address bits truncated
        exp_wr.push_back(wr(12'h005, 8'h77));
        exp_tx.push_back(8'h2E);
        send(8'h4C); send(8'hFE); send(8'h05); send(8'h01); send(8'h77);
        drain(200);

        // Count 0 means 256 bytes
        for (int i = 0; i < 256; i++) exp_wr.push_back(wr(12'h080 + i, 8'(i ^ 8'h5A)));
        exp_tx.push_back(8'h2E);
        send(8'h4C); send(8'h00); send(8'h80); send(8'h00);
        for (int i = 0; i < 256; i++) send(8'(i ^ 8'h5A));
        drain(400);

        // Go, bytes ignored while running, halt coincident with a byte
        exp_startaddr = 9'h020;
        send(8'h47); send(8'h00); send(8'h20);
        send(8'h4C); send(8'h00); send(8'h30); send(8'h01); send(8'h99);
        check("start_pulse_cycles", start_cycles, 1);
        check("busy_running", bus.busy, 1);
        check("startaddr", bus.cpu_startaddr, 9'h020);
        @(negedge clk);
        exp_tx.push_back(8'h48);
        bus.cpu_halted = 1'b1;
        bus.rx_byte    = 8'h52;
        bus.received   = 1'b1;
        @(negedge clk);
        bus.cpu_halted = 1'b0;
        bus.received   = 1'b0;
        check("busy_fall", bus.busy, 0);
        check("no_tx_same_cycle_as_fall", bus.transmit, 0);
        drain(100);

        // Unknown command, then a normal read
        exp_tx.push_back(8'h3F);
        send(8'h55);
        drain(100);
        exp_tx.push_back(8'hAA); exp_tx.push_back(8'hBB);
        send(8'h52); send(8'h00); send(8'h10); send(8'h02);
        drain(300);

        // Reset after the second data byte of a 4-byte load
        exp_wr.push_back(wr(12'h040, 8'hD1));
        exp_wr.push_back(wr(12'h041, 8'hD2));
        send(8'h4C); send(8'h00); send(8'h40); send(8'h04); send(8'hD1); send(8'hD2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("midreset");
        repeat (30) @(negedge clk);
        check("midreset_writes_left", exp_wr.size(), 0);

        // Reset coincident with a data byte suppresses its write strobe
        send(8'h4C); send(8'h00); send(8'h50); send(8'h02);
        @(negedge clk);
        bus.rx_byte  = 8'hE1;
        bus.received = 1'b1;
        rst          = 1'b1;
        @(negedge clk);
        bus.received = 1'b0;
        rst          = 1'b0;
        check("suppressed_we", bus.mem_write_en, 0);
        repeat (30) @(negedge clk);
        check("final_state_idle_busy", bus.busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/serial_loader.md
# serial_loader

Host-side monitor that owns the UART and the program RAM while the CPU is idle. It loads bytes received over serial into RAM and reads RAM back over serial. It starts the CPU at a host-chosen address, then reports back when the CPU halts. It is the host end of the CPU's start/halt, memory and UART interfaces; `busy` steers the RAM and UART muxes to the CPU while it runs.

## Interface
- `addr_width`, 9, RAM address width; must be 9..16.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `rx_byte`  in  8  byte from UART receiver; valid while `received` is high.
- `received`  in  1  one-cycle pulse, new `rx_byte`.
- `tx_byte`  out  8  byte to UART transmitter.
- `transmit`  out  1  one-cycle pulse, start sending `tx_byte`.
- `is_transmitting`  in  1  UART transmitter busy.
- `mem_raddr`  out  addr_width  RAM read address.
- `mem_dread`  in  8  RAM read data; valid 2 cycles after `mem_raddr` is registered.
- `mem_waddr`  out  addr_width  RAM write address.
- `mem_dwrite`  out  8  RAM write data.
- `mem_write_en`  out  1  RAM write strobe, one cycle per byte.
- `cpu_start`  out  1  one-cycle pulse to the CPU start/reset input.
- `cpu_startaddr`  out  addr_width  CPU start address; held stable while `busy`.
- `cpu_halted`  in  1  one-cycle pulse from the CPU on HLT.
- `busy`  out  1  high from the `cpu_start` pulse until `cpu_halted`; the CPU owns RAM and UART.

## Operation
- Commands are byte streams. Address is sent as 2 bytes, high then low; the block keeps the low `addr_width` bits of {hi,lo}.
- `L` (0x4C), addr, count, then count data bytes:
  - Each data byte is written to addr, addr+1, and so on.
  - After the last write, the block transmits `.` (0x2E).
- `R` (0x52), addr, count: the block transmits count bytes read from addr upward.
- `G` (0x47), addr: the block loads `cpu_startaddr`, pulses `cpu_start`, and sets `busy`. On `cpu_halted` it clears `busy` and transmits `H` (0x48).
- Any other first byte: the block transmits `?` (0x3F) and returns to IDLE.
- Count byte 0 means 256. Address increments wrap modulo 2^addr_width.
- States: IDLE, ADDRH, ADDRL, COUNT, LOAD, RDADDR, RDWAIT1, RDWAIT2, RDSEND, TXGUARD, RUN, REPLY.
  - IDLE -> ADDRH on L/R/G; IDLE -> REPLY on an unknown byte.
  - ADDRH -> ADDRL.
  - ADDRL -> COUNT for L/R. For G, ADDRL -> RUN; the `cpu_start` pulse fires on that transition.
  - COUNT -> LOAD (L) or RDADDR (R).
  - LOAD stays until count bytes are written, then -> REPLY.
  - RDADDR -> RDWAIT1 -> RDWAIT2 -> RDSEND.
  - RDSEND waits for `!is_transmitting`, pulses `transmit`, and goes -> TXGUARD.
  - TXGUARD -> RDADDR if bytes remain, else -> IDLE.
  - RUN -> REPLY on `cpu_halted`.
  - REPLY waits for `!is_transmitting`, pulses `transmit`, and goes -> IDLE.
- In ADDRH/ADDRL/COUNT/LOAD the block advances only on `received`; it waits indefinitely with no timeout.
- In RUN and every read/reply state, `received` is ignored and the byte is dropped.
- `cpu_halted` outside RUN is ignored.
- `mem_write_en` is never asserted while `busy` or outside LOAD.

## Timing
- Reset: state IDLE. All outputs are 0: `tx_byte`, `transmit`, `mem_raddr`, `mem_waddr`, `mem_dwrite`, `mem_write_en`, `cpu_start`, `cpu_startaddr`, `busy`.
- Reset mid-command aborts without a reply. A write strobe pending in that cycle is suppressed.
- Write latency: `received` in LOAD at cycle n gives `mem_write_en`=1 at cycle n+1, with `mem_waddr`/`mem_dwrite` valid in that cycle. The strobe is 0 otherwise.
- Read: `mem_raddr` is registered on entry to RDWAIT1. `mem_dread` is sampled in RDSEND, 2 cycles later, and copied to `tx_byte` with the `transmit` pulse.
- TXGUARD is exactly 1 cycle. It lets `is_transmitting` rise before the next check.
- `cpu_start` is high exactly 1 cycle. `busy` rises in the same cycle.
- `busy` falls the cycle after `cpu_halted`. The `H` transmit happens no earlier than the cycle after that.
- A `received` pulse and `cpu_halted` in the same RUN cycle: the halt is taken and the byte is dropped.

## Test plan
- `L` 0x00 0x10 0x03 AA BB CC -> three single-cycle `mem_write_en` pulses at 0x010/0x011/0x012 with AA/BB/CC, then `tx_byte`=0x2E.
- After that load, `R` 0x00 0x10 0x03 -> three `transmit` pulses carrying AA, BB, CC. Each pulse waits for `is_transmitting` to drop; the bench models a 10-cycle busy.
- `L` 0x01 0xFF 0x02 11 22 -> writes at 0x1FF then 0x000. `L` 0xFE 0x05 … -> first write at 0x005 (high bits truncated). `L` with count 0 -> exactly 256 writes, then 0x2E.
- `G` 0x00 0x20 -> `cpu_startaddr`=0x020 and a 1-cycle `cpu_start`. `busy`=1 until the `cpu_halted` pulse. Bytes sent during RUN produce no writes and no replies. Then `tx_byte`=0x48.
- First byte 0x55 -> `tx_byte`=0x3F, state IDLE. A following `R` command works normally.
- `rst` asserted after the 2nd data byte of a 4-byte `L` -> no further writes, no 0x2E. All outputs are 0 the cycle after reset.
